// File: rtl/axi4_pkg.sv
// Shared AXI4 types and helpers for the write-channel interconnect blocks.
// Holds the AW field enums, the default AW beat record and the round-robin picker.
package axi4_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_LEN_WIDTH  = 8;
   localparam int RR_MAX_PORTS   = 32;

   typedef enum logic [1:0] {
      BURST_FIXED    = 2'd0,
      BURST_INCR     = 2'd1,
      BURST_WRAP     = 2'd2,
      BURST_RESERVED = 2'd3
   } axi_burst_e;

   typedef enum logic {
      LOCK_NORMAL    = 1'b0,
      LOCK_EXCLUSIVE = 1'b1
   } axi_lock_e;

   typedef logic [2:0] axi_prot_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [AXI_LEN_WIDTH-1:0]  len;
      axi_burst_e                burst;
      axi_lock_e                 lock;
      axi_prot_t                 prot;
   } axi4_aw_beat_t;

   // First set bit of req at or after ptr, wrapping; callers zero-extend req,
   // so the unused upper bits never win and the wrap order matches N ports.
   function automatic int rr_pick(input logic [RR_MAX_PORTS-1:0] req, input int ptr);
      int   pick;
      int   idx;
      logic found;
      pick  = 0;
      found = 1'b0;
      for (int i = 0; i < RR_MAX_PORTS; i++) begin
         idx = (ptr + i) % RR_MAX_PORTS;
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axi4_idx_fifo.sv
// Small synchronous FIFO of port indices; remembers which master owns the
// W channel for each accepted AW burst, oldest first.
module axi4_idx_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
   logic [PTR_W:0]   count_q;
   logic             doPush, doPop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign data_o  = mem_q[rdPtr_q];

   always_ff @(posedge aclk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/axi4_aw_w_arbiter.sv
// N-to-1 round-robin arbiter for a shared AXI4 AW channel with a registered
// output stage; W beats follow AW acceptance order through an index FIFO.
module axi4_aw_w_arbiter
   import axi4_pkg::*;
#(
   parameter int N_PORTS      = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int ID_WIDTH     = 4,
   parameter int DATA_WIDTH   = 64,
   parameter int W_FIFO_DEPTH = 4,
   localparam int IDX_W       = $clog2(N_PORTS),
   localparam int STRB_W      = DATA_WIDTH / 8
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [N_PORTS-1:0]             s_awvalid,
   output logic [N_PORTS-1:0]             s_awready,
   input  logic [N_PORTS*ID_WIDTH-1:0]    s_awid,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]  s_awaddr,
   input  logic [N_PORTS*8-1:0]           s_awlen,
   input  logic [N_PORTS*2-1:0]           s_awburst,
   input  logic [N_PORTS-1:0]             s_awlock,
   input  logic [N_PORTS*3-1:0]           s_awprot,
   input  logic [N_PORTS-1:0]             s_wvalid,
   input  logic [N_PORTS-1:0]             s_wlast,
   input  logic [N_PORTS*DATA_WIDTH-1:0]  s_wdata,
   input  logic [N_PORTS*STRB_W-1:0]      s_wstrb,
   output logic [N_PORTS-1:0]             s_wready,
   output logic                           m_awvalid,
   input  logic                           m_awready,
   output logic [ID_WIDTH+IDX_W-1:0]      m_awid,
   output logic [ADDR_WIDTH-1:0]          m_awaddr,
   output logic [7:0]                     m_awlen,
   output logic [1:0]                     m_awburst,
   output logic                           m_awlock,
   output logic [2:0]                     m_awprot,
   output logic                           m_wvalid,
   output logic                           m_wlast,
   input  logic                           m_wready,
   output logic [DATA_WIDTH-1:0]          m_wdata,
   output logic [STRB_W-1:0]              m_wstrb
);

   // Local record mirrors axi4_aw_beat_t but follows this instance's widths.
   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [ADDR_WIDTH-1:0] addr;
      logic [7:0]            len;
      axi_burst_e            burst;
      axi_lock_e             lock;
      axi_prot_t             prot;
   } aw_beat_t;

   arb_state_e       state_q, state_d;
   aw_beat_t         awBeat_q, awBeat_d;
   logic [IDX_W-1:0] awIdx_q, awIdx_d;
   logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] wHead;
   logic             grant, fifoFull, fifoEmpty, wPop;

   assign winner = IDX_W'(rr_pick(RR_MAX_PORTS'(s_awvalid), int'(rrPtr_q)));

   // Grant only from IDLE on the registered full flag, so a same-cycle pop
   // never opens a slot early; reset is folded in to keep s_awready low.
   always_comb begin
      state_d   = state_q;
      awBeat_d  = awBeat_q;
      awIdx_d   = awIdx_q;
      rrPtr_d   = rrPtr_q;
      grant     = 1'b0;
      s_awready = '0;
      case (state_q)
         ARB_IDLE: begin
            if (aresetn && (|s_awvalid) && !fifoFull) begin
               grant             = 1'b1;
               s_awready[winner] = 1'b1;
               awBeat_d.id       = s_awid[winner*ID_WIDTH +: ID_WIDTH];
               awBeat_d.addr     = s_awaddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
               awBeat_d.len      = s_awlen[winner*8 +: 8];
               awBeat_d.burst    = axi_burst_e'(s_awburst[winner*2 +: 2]);
               awBeat_d.lock     = axi_lock_e'(s_awlock[winner]);
               awBeat_d.prot     = s_awprot[winner*3 +: 3];
               awIdx_d           = winner;
               rrPtr_d           = (winner == IDX_W'(N_PORTS - 1)) ? '0 : winner + IDX_W'(1);
               state_d           = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (m_awready) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= ARB_IDLE;
         awBeat_q <= '0;
         awIdx_q  <= '0;
         rrPtr_q  <= '0;
      end else begin
         state_q  <= state_d;
         awBeat_q <= awBeat_d;
         awIdx_q  <= awIdx_d;
         rrPtr_q  <= rrPtr_d;
      end
   end

   assign m_awvalid = (state_q == ARB_BUSY);
   assign m_awid    = {awIdx_q, awBeat_q.id};
   assign m_awaddr  = awBeat_q.addr;
   assign m_awlen   = awBeat_q.len;
   assign m_awburst = awBeat_q.burst;
   assign m_awlock  = awBeat_q.lock;
   assign m_awprot  = awBeat_q.prot;

   axi4_idx_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (W_FIFO_DEPTH)
   ) u_wOwnerFifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push_i  (grant),
      .data_i  (winner),
      .pop_i   (wPop),
      .data_o  (wHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   // The FIFO head owns the W channel until its WLAST beat is accepted.
   always_comb begin
      m_wvalid = 1'b0;
      m_wlast  = 1'b0;
      m_wdata  = '0;
      m_wstrb  = '0;
      s_wready = '0;
      if (!fifoEmpty) begin
         m_wvalid        = s_wvalid[wHead];
         m_wlast         = s_wlast[wHead];
         m_wdata         = s_wdata[wHead*DATA_WIDTH +: DATA_WIDTH];
         m_wstrb         = s_wstrb[wHead*STRB_W +: STRB_W];
         s_wready[wHead] = m_wready;
      end
   end

   assign wPop = m_wvalid & m_wready & m_wlast;

endmodule

// File: tb/tb_axi4_aw_w_arbiter.sv
// Bench for axi4_aw_w_arbiter: table of cycle vectors, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_axi4_aw_w_arbiter;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic [3:0]   s_awvalid, s_awready;
   logic [15:0]  s_awid;
   logic [127:0] s_awaddr;
   logic [31:0]  s_awlen;
   logic [7:0]   s_awburst;
   logic [3:0]   s_awlock;
   logic [11:0]  s_awprot;
   logic [3:0]   s_wvalid, s_wlast, s_wready;
   logic [255:0] s_wdata;
   logic [31:0]  s_wstrb;
   logic         m_awvalid, m_awready;
   logic [5:0]   m_awid;
   logic [31:0]  m_awaddr;
   logic [7:0]   m_awlen;
   logic [1:0]   m_awburst;
   logic         m_awlock;
   logic [2:0]   m_awprot;
   logic         m_wvalid, m_wlast, m_wready;
   logic [63:0]  m_wdata;
   logic [7:0]   m_wstrb;

   int checks = 0;
   int failures = 0;

   axi4_aw_w_arbiter dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
      .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
      .s_awlock(s_awlock), .s_awprot(s_awprot),
      .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_wready(s_wready),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
      .m_awlock(m_awlock), .m_awprot(m_awprot),
      .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0] awvalid;
      logic       mAwready;
      logic [3:0] wvalid;
      logic [3:0] wlast;
      logic       mWready;
      logic [3:0] expAwready;
      logic       expMAwvalid;
      logic [5:0] expMAwid;
      logic [3:0] expWready;
      logic       expMWvalid;
      logic       expMWlast;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mkVec(input logic [3:0] awv, input logic awr, input logic [3:0] wv,
                                  input logic [3:0] wl, input logic wr, input logic [3:0] eAwr,
                                  input logic eAwv, input logic [5:0] eId, input logic [3:0] eWr,
                                  input logic eWv, input logic eWl);
      vec_t v;
      v.awvalid = awv; v.mAwready = awr; v.wvalid = wv; v.wlast = wl; v.mWready = wr;
      v.expAwready = eAwr; v.expMAwvalid = eAwv; v.expMAwid = eId;
      v.expWready = eWr; v.expMWvalid = eWv; v.expMWlast = eWl;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      s_awvalid = '0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awburst = '0;
      s_awlock = '0; s_awprot = '0; s_wvalid = '0; s_wlast = '0; s_wdata = '0;
      s_wstrb = '0; m_awready = 1'b0; m_wready = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge aclk);
      #1;
   endtask

   task automatic doReset();
      aresetn = 1'b0;
      clearInputs();
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
   endtask

   task automatic setPortFields(input int p, input logic [3:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [1:0] burst,
                                input logic lock, input logic [2:0] prot);
      s_awid[p*4 +: 4]     = id;
      s_awaddr[p*32 +: 32] = addr;
      s_awlen[p*8 +: 8]    = len;
      s_awburst[p*2 +: 2]  = burst;
      s_awlock[p]          = lock;
      s_awprot[p*3 +: 3]   = prot;
   endtask

   task automatic applyStimulus(input vec_t v);
      s_awvalid = v.awvalid;
      m_awready = v.mAwready;
      s_wvalid  = v.wvalid;
      s_wlast   = v.wlast;
      m_wready  = v.mWready;
   endtask

   // Reference model state: owner queue, RR pointer, and expected AW registers.
   int          mq[$];
   int          mPtr;
   bit          mBusy;
   logic [63:0] mAwid, mAddr, mLen, mBurst, mLock, mProt;

   initial begin
      int  h, win;
      bit  grant, pop;

      vecs[0]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h1, 0, 6'h00, 4'h0, 0, 0);
      vecs[1]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h0, 1, 6'h05, 4'h1, 0, 0);
      vecs[2]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h2, 0, 6'h05, 4'h1, 0, 0);
      vecs[3]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h0, 1, 6'h16, 4'h1, 0, 0);
      vecs[4]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h4, 0, 6'h16, 4'h1, 0, 0);
      vecs[5]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h0, 1, 6'h27, 4'h1, 0, 0);
      vecs[6]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h8, 0, 6'h27, 4'h1, 0, 0);
      vecs[7]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h0, 1, 6'h38, 4'h1, 0, 0);
      vecs[8]  = mkVec(4'hF, 1, 4'h1, 4'h1, 1, 4'h0, 0, 6'h38, 4'h1, 1, 1);
      vecs[9]  = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h1, 0, 6'h38, 4'h2, 0, 0);
      vecs[10] = mkVec(4'hF, 0, 4'h0, 4'h0, 1, 4'h0, 1, 6'h05, 4'h2, 0, 0);
      vecs[11] = mkVec(4'hF, 0, 4'h0, 4'h0, 1, 4'h0, 1, 6'h05, 4'h2, 0, 0);
      vecs[12] = mkVec(4'hF, 0, 4'h8, 4'h8, 1, 4'h0, 1, 6'h05, 4'h2, 0, 0);
      vecs[13] = mkVec(4'hF, 0, 4'h8, 4'h8, 1, 4'h0, 1, 6'h05, 4'h2, 0, 0);
      vecs[14] = mkVec(4'hF, 0, 4'h8, 4'h8, 1, 4'h0, 1, 6'h05, 4'h2, 0, 0);
      vecs[15] = mkVec(4'hF, 1, 4'hA, 4'h2, 1, 4'h0, 1, 6'h05, 4'h2, 1, 1);
      vecs[16] = mkVec(4'hF, 1, 4'h8, 4'h0, 1, 4'h2, 0, 6'h05, 4'h4, 0, 0);
      vecs[17] = mkVec(4'hF, 1, 4'h0, 4'h0, 1, 4'h0, 1, 6'h16, 4'h4, 0, 0);

      // Reset state, checked while reset is held and just after release.
      clearInputs();
      #2;
      checkOutput("rst_m_awvalid", m_awvalid, 0);
      checkOutput("rst_m_wvalid", m_wvalid, 0);
      doReset();
      #3;
      checkOutput("rst_s_awready", s_awready, 0);
      checkOutput("rst_s_wready", s_wready, 0);
      checkOutput("rst_m_awaddr", m_awaddr, 0);
      checkOutput("rst_m_awid", m_awid, 0);

      // Round robin, back-pressure, FIFO-full and W-interleave table.
      doReset();
      for (int p = 0; p < 4; p++) begin
         setPortFields(p, 4'(5 + p), 32'(256 * (p + 1)), 8'(p + 1), 2'(p), 1'(p), 3'(p));
      end
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i]);
         #3;
         checkOutput($sformatf("vec%0d_s_awready", i), s_awready, vecs[i].expAwready);
         checkOutput($sformatf("vec%0d_m_awvalid", i), m_awvalid, vecs[i].expMAwvalid);
         checkOutput($sformatf("vec%0d_m_awid", i), m_awid, vecs[i].expMAwid);
         checkOutput($sformatf("vec%0d_s_wready", i), s_wready, vecs[i].expWready);
         checkOutput($sformatf("vec%0d_m_wvalid", i), m_wvalid, vecs[i].expMWvalid);
         checkOutput($sformatf("vec%0d_m_wlast", i), m_wlast, vecs[i].expMWlast);
         nextCycle();
      end

      // Single master on port 2 with a four-beat burst.
      doReset();
      setPortFields(2, 4'd3, 32'h1000, 8'd3, 2'd1, 1'b0, 3'd0);
      s_awvalid = 4'b0100; m_awready = 1'b1; m_wready = 1'b1;
      #3;
      checkOutput("sm_s_awready", s_awready, 4'b0100);
      checkOutput("sm_m_awvalid_T", m_awvalid, 0);
      nextCycle();
      s_awvalid = 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         s_wvalid = 4'b0100;
         s_wdata[2*64 +: 64] = 64'hCAFE_0000 + 64'(k);
         s_wstrb[2*8 +: 8] = 8'hF0 | 8'(k);
         s_wlast = (k == 4) ? 4'b0100 : 4'b0000;
         #3;
         if (k == 1) begin
            checkOutput("sm_m_awvalid_T1", m_awvalid, 1);
            checkOutput("sm_m_awid", m_awid, 6'h23);
            checkOutput("sm_m_awaddr", m_awaddr, 32'h1000);
            checkOutput("sm_m_awlen", m_awlen, 8'd3);
         end
         checkOutput($sformatf("sm_beat%0d_m_wvalid", k), m_wvalid, 1);
         checkOutput($sformatf("sm_beat%0d_m_wdata", k), m_wdata, 64'hCAFE_0000 + 64'(k));
         checkOutput($sformatf("sm_beat%0d_m_wstrb", k), m_wstrb, 8'hF0 | 8'(k));
         checkOutput($sformatf("sm_beat%0d_m_wlast", k), m_wlast, (k == 4));
         checkOutput($sformatf("sm_beat%0d_s_wready", k), s_wready, 4'b0100);
         nextCycle();
      end
      s_wvalid = 4'b0100; s_wlast = 4'b0000;
      #3;
      checkOutput("sm_after_m_wvalid", m_wvalid, 0);
      checkOutput("sm_after_s_wready", s_wready, 0);
      checkOutput("sm_after_m_awvalid", m_awvalid, 0);

      // Reset asserted between edges in the middle of a burst.
      doReset();
      setPortFields(1, 4'd9, 32'hABCD_0000, 8'd3, 2'd1, 1'b0, 3'd2);
      s_awvalid = 4'b0010; m_awready = 1'b1; m_wready = 1'b1;
      #3;
      checkOutput("mr_s_awready", s_awready, 4'b0010);
      nextCycle();
      s_awvalid = 4'b0000;
      for (int k = 1; k <= 2; k++) begin
         s_wvalid = 4'b0010; s_wlast = 4'b0000;
         #3;
         checkOutput($sformatf("mr_beat%0d_m_wvalid", k), m_wvalid, 1);
         nextCycle();
      end
      s_awvalid = 4'b1000;
      #3;
      checkOutput("mr_beat3_m_wvalid", m_wvalid, 1);
      checkOutput("mr_pre_s_awready", s_awready, 4'b1000);
      #1 aresetn = 1'b0;
      #1;
      checkOutput("mr_rst_m_awvalid", m_awvalid, 0);
      checkOutput("mr_rst_s_awready", s_awready, 0);
      checkOutput("mr_rst_s_wready", s_wready, 0);
      checkOutput("mr_rst_m_wvalid", m_wvalid, 0);
      checkOutput("mr_rst_m_awaddr", m_awaddr, 0);
      checkOutput("mr_rst_m_awid", m_awid, 0);
      nextCycle();
      aresetn = 1'b1;
      s_awvalid = 4'b1111;
      #3;
      checkOutput("mr_first_grant", s_awready, 4'b0001);

      // Random traffic against the reference model.
      doReset();
      mq.delete();
      mPtr = 0; mBusy = 0;
      mAwid = 0; mAddr = 0; mLen = 0; mBurst = 0; mLock = 0; mProt = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         s_awvalid = 4'($urandom_range(0, 15));
         for (int p = 0; p < 4; p++) begin
            setPortFields(p, 4'($urandom), $urandom, 8'($urandom), 2'($urandom),
                          1'($urandom), 3'($urandom));
            s_wdata[p*64 +: 64] = {$urandom, $urandom};
            s_wstrb[p*8 +: 8]   = 8'($urandom);
            s_wlast[p]          = ($urandom_range(0, 2) == 0);
         end
         s_wvalid  = 4'($urandom_range(0, 15));
         m_awready = ($urandom_range(0, 3) != 0);
         m_wready  = ($urandom_range(0, 3) != 0);
         #3;
         grant = 0; win = 0; pop = 0;
         if (!mBusy && s_awvalid != 4'b0 && mq.size() < 4) begin
            for (int k = 0; k < 4; k++) begin
               if (!grant && s_awvalid[(mPtr + k) % 4]) begin
                  grant = 1;
                  win = (mPtr + k) % 4;
               end
            end
         end
         checkOutput("rnd_s_awready", s_awready, grant ? (64'd1 << win) : 64'd0);
         checkOutput("rnd_m_awvalid", m_awvalid, mBusy);
         checkOutput("rnd_m_awid", m_awid, mAwid);
         checkOutput("rnd_m_awaddr", m_awaddr, mAddr);
         checkOutput("rnd_m_awlen", m_awlen, mLen);
         checkOutput("rnd_m_awburst", m_awburst, mBurst);
         checkOutput("rnd_m_awlock", m_awlock, mLock);
         checkOutput("rnd_m_awprot", m_awprot, mProt);
         if (mq.size() > 0) begin
            h = mq[0];
            checkOutput("rnd_m_wvalid", m_wvalid, s_wvalid[h]);
            checkOutput("rnd_s_wready", s_wready, 64'(m_wready) << h);
            checkOutput("rnd_m_wdata", m_wdata, s_wdata[h*64 +: 64]);
            checkOutput("rnd_m_wstrb", m_wstrb, s_wstrb[h*8 +: 8]);
            checkOutput("rnd_m_wlast", m_wlast, s_wlast[h]);
            pop = s_wvalid[h] && m_wready && s_wlast[h];
         end else begin
            checkOutput("rnd_m_wvalid_empty", m_wvalid, 0);
            checkOutput("rnd_s_wready_empty", s_wready, 0);
         end
         if (pop) mq.delete(0);
         if (grant) begin
            mq.push_back(win);
            mPtr   = (win + 1) % 4;
            mBusy  = 1;
            mAwid  = 64'(win * 16) + 64'(s_awid[win*4 +: 4]);
            mAddr  = 64'(s_awaddr[win*32 +: 32]);
            mLen   = 64'(s_awlen[win*8 +: 8]);
            mBurst = 64'(s_awburst[win*2 +: 2]);
            mLock  = 64'(s_awlock[win]);
            mProt  = 64'(s_awprot[win*3 +: 3]);
         end else if (mBusy && m_awready) begin
            mBusy = 0;
         end
         nextCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi4_aw_w_arbiter.md
Name: axi4_aw_w_arbiter

Overview:
N-to-1 arbiter sharing one downstream AXI4 write-address (AW) channel and its write-data (W) channel between N upstream masters inside the coherent interconnect. Round-robin grant on AW, registered output stage. An in-order W-ownership FIFO routes each write burst's W beats to the downstream port until WLAST. Downstream AWID is widened with the granted port index so B responses can be routed back.

Parameters:
N_PORTS, 4, number of upstream masters (>=2)
ADDR_WIDTH, 32, address width
ID_WIDTH, 4, upstream AWID width
DATA_WIDTH, 64, W data width; strobe width DATA_WIDTH/8
W_FIFO_DEPTH, 4, outstanding AW bursts whose W data is not yet complete (power of 2)
IDX_W, $clog2(N_PORTS), derived, port index width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_awvalid  in  N_PORTS  per-port AW valid
s_awready  out  N_PORTS  per-port AW ready
s_awid  in  N_PORTS*ID_WIDTH  packed per-port AWID
s_awaddr  in  N_PORTS*ADDR_WIDTH  packed AWADDR
s_awlen  in  N_PORTS*8  packed AWLEN
s_awburst  in  N_PORTS*2  packed axi_burst
s_awlock  in  N_PORTS  axi_lock
s_awprot  in  N_PORTS*3  packed axi_prot
s_wvalid / s_wlast  in  N_PORTS each  per-port W valid / last
s_wdata  in  N_PORTS*DATA_WIDTH  packed WDATA
s_wstrb  in  N_PORTS*DATA_WIDTH/8  packed WSTRB
s_wready  out  N_PORTS  per-port W ready
m_awvalid  out  1; m_awready  in  1  downstream AW handshake
m_awid  out  ID_WIDTH+IDX_W  {port index, upstream AWID}
m_awaddr/m_awlen/m_awburst/m_awlock/m_awprot  out  ADDR_WIDTH/8/2/1/3  registered AW fields
m_wvalid/m_wlast  out  1; m_wready  in  1
m_wdata/m_wstrb  out  DATA_WIDTH, DATA_WIDTH/8

Behaviour:
- Reset (async, aresetn=0): m_awvalid=0, s_awready=0, s_wready=0, m_wvalid=0, m_aw* fields=0, RR pointer=0 (port 0 highest priority), FIFO empty, FSM=IDLE. Mid-burst reset discards everything. Nothing is replayed.
- FSM IDLE: if any s_awvalid and FIFO not full, pick the winner. The winner is the first requesting port at or after the RR pointer, wrapping modulo N_PORTS.
- In the same cycle: s_awready[winner]=1 (combinational, only the winner). Fields are captured into the output registers. The winner index is pushed into the W FIFO. RR pointer <= winner+1 (wraps). Go to BUSY.
- FSM BUSY: m_awvalid=1 and fields held stable until m_awready. On handshake go to IDLE. One bubble cycle; max throughput is one AW per 2 cycles. All s_awready=0 in BUSY.
- FIFO full in IDLE: no grant and no s_awready, even if a pop occurs the same cycle. The full flag is registered-state based.
- Latency: upstream accept at cycle T gives m_awvalid at T+1 at the earliest.
- W routing is combinational from the FIFO head h, when FIFO not empty:
  - m_wvalid=s_wvalid[h]; m_wdata/m_wstrb/m_wlast from port h.
  - s_wready[h]=m_wready; all other s_wready=0.
- FIFO empty: m_wvalid=0, all s_wready=0.
- W beats may pass downstream before the matching m_awvalid handshake, because the push happens at upstream accept.
- Pop on m_wvalid&m_wready&m_wlast. Push and pop in the same cycle leave the count unchanged.
- Beat counting vs AWLEN is not checked; WLAST alone terminates ownership.
- Fields pass through unmodified, including burst=RESERVED and lock=EXCLUSIVE. Only AWID is widened.
- AXI rule: an asserted m_awvalid/m_wvalid never drops without handshake, except on reset.

Decomposition:
- axi4_pkg gains: axi_burst, axi_lock and axi_prot (reused), plus a packed struct axi4_aw_beat_t {id, addr, len, burst, lock, prot} parameterised via localparam widths, and a function rr_pick(req, ptr) returning the index.
- One sub-module: axi4_idx_fifo (sync FIFO of IDX_W-bit entries, depth W_FIFO_DEPTH, full/empty flags, same aclk/aresetn).

Test Plan:
- Single master: port 2 sends AW id=3 addr=0x1000 len=3 then 4 W beats. Expect m_awid={2,3}, m_awvalid at T+1, 4 beats routed with wlast on beat 4, FIFO empty afterwards.
- All 4 ports valid continuously, m_awready=1. Grants are ordered 0,1,2,3,0,... with one s_awready per grant and one AW per 2 cycles.
- m_awready held 0 for 5 cycles in BUSY. m_aw* stays stable, m_awvalid stays 1, and no s_awready is asserted.
- W_FIFO_DEPTH=4: issue 4 AWs with no W data, then a 5th request. The 5th gets no s_awready until the first wlast handshake, and is granted in the first IDLE cycle after the pop.
- W interleave guard: FIFO holds ports 1 then 3, and port 3 drives W first. s_wready[3]=0 until port 1's wlast pops, then port 3's beats flow.
- Reset asserted mid-burst (beat 2 of 4). All outputs return to 0 immediately, and after release the arbiter grants port 0 first.
